// File: rtl/masked_conn_pkg.sv
// Shared types and mask helpers for the masked lane<->memory connectors.
package masked_conn_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    ACCEPT,
    FLUSH
  } state_t;

  // Number of set bits among mask[0 .. n-1].
  function automatic int unsigned popcount(input logic [MAX_W-1:0] mask, input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < n && mask[i]) cnt++;
    end
    return cnt;
  endfunction

  // Packed position of lane 'lane' = enabled lanes strictly below it.
  function automatic int unsigned prefix_offset(input logic [MAX_W-1:0] mask, input int unsigned lane);
    return popcount(mask, lane);
  endfunction

endpackage

// File: rtl/masked_l2m_compactor.sv
// Squeezes the enabled lanes of one beat into the low bytes of a word, zero-filled above.
module masked_l2m_compactor
  import masked_conn_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned BYTE_BIT = 8
) (
  input  logic [W-1:0]               mask,
  input  logic [W*BYTE_BIT-1:0]      data,
  output logic [W*BYTE_BIT-1:0]      packed_data,
  output logic [$clog2(W+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [CW-1:0] pos;

  // Offset chain: each enabled lane lands at the running count of enabled lanes below it.
  always_comb begin
    pos         = '0;
    packed_data = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (mask[i]) begin
        packed_data[pos*BYTE_BIT +: BYTE_BIT] = data[i*BYTE_BIT +: BYTE_BIT];
        pos = pos + CW'(1);
      end
    end
    count = CW'(popcount(MAX_W'(mask), W));
  end

endmodule

// File: rtl/masked_l2m_packer.sv
// Packs byte-masked lane beats into contiguous W-byte words; flushes a partial word at burst end.
module masked_l2m_packer
  import masked_conn_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned BYTE_BIT = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [W-1:0]               IN_MASK,
  input  logic [W*BYTE_BIT-1:0]      IN_DATA,
  input  logic                       IN_LAST,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [W*BYTE_BIT-1:0]      OUT_DATA,
  output logic [$clog2(W+1)-1:0]     OUT_COUNT,
  output logic                       OUT_LAST
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned FW = $clog2(2 * W);
  localparam int unsigned WB = W * BYTE_BIT;

  state_t          state_q, state_d;
  logic [FW-1:0]   fill_q, fill_d, fill_p;
  logic [2*WB-1:0] buf_q, buf_d, buf_p;
  logic [WB-1:0]   pk_data;
  logic [CW-1:0]   pk_count;
  logic            pop, accept;

  masked_l2m_compactor #(
    .W        (W),
    .BYTE_BIT (BYTE_BIT)
  ) u_compactor (
    .mask        (IN_MASK),
    .data        (IN_DATA),
    .packed_data (pk_data),
    .count       (pk_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ACCEPT;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Handshakes, pop-then-append buffer update and next state.
  always_comb begin
    state_d   = state_q;
    fill_p    = fill_q;
    buf_p     = buf_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    OUT_COUNT = '0;
    OUT_LAST  = 1'b0;
    OUT_DATA  = '0;
    pop       = 1'b0;
    accept    = 1'b0;
    if (!RST) begin
      // Bytes above FILL are held at zero, so the low word is already zero-padded.
      OUT_DATA = buf_q[WB-1:0];
      unique case (state_q)
        ACCEPT: begin
          OUT_VALID = (fill_q >= FW'(W));
          OUT_COUNT = CW'(W);
          IN_READY  = (fill_q < FW'(W)) || OUT_READY;
        end
        FLUSH: begin
          OUT_VALID = 1'b1;
          OUT_LAST  = (fill_q <= FW'(W));
          OUT_COUNT = OUT_LAST ? CW'(fill_q) : CW'(W);
        end
        default: ;
      endcase

      pop    = OUT_VALID && OUT_READY;
      accept = IN_VALID && IN_READY;

      if (pop) begin
        if (OUT_LAST) begin
          fill_p  = '0;
          buf_p   = '0;
          state_d = ACCEPT;
        end else begin
          fill_p = fill_q - FW'(W);
          buf_p  = buf_q >> WB;
        end
      end

      fill_d = fill_p;
      buf_d  = buf_p;
      if (accept) begin
        fill_d = fill_p + FW'(pk_count);
        buf_d  = buf_p | ({{WB{1'b0}}, pk_data} << (32'(fill_p) * BYTE_BIT));
        if (IN_LAST) state_d = FLUSH;
      end
    end
  end

endmodule
